// File: rtl/bit_modify_unit.sv
// bit_modify_unit
//   Holds a WIDTH-bit data register. Accepts one command at a time, which may
//   load it, set/clear/toggle a single bit, or sweep a range of bits
//   (position down to 0). A sweep sets or clears one bit per clock.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   cmd_valid  : a command is presented this cycle
//   cmd_ready  : command can be accepted this cycle (IDLE)
//   cmd_op     : operation code (NOP/LOAD/SET/CLR/TOGGLE/SWEEP_SET/SWEEP_CLR)
//   position   : target bit index
//   data_in    : load value for LOAD
//   data_out   : current data register contents
//   ones_count : number of 1 bits in data_out (combinational)
//   busy       : a sweep is in progress
//   done       : one-cycle pulse when a command completes
//   err        : one-cycle pulse when a command is rejected (position out of range)
module bit_modify_unit #(
  parameter int WIDTH = 8,
  parameter int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [POS_W-1:0]   position,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic [POS_W:0]     ones_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOAD      = 3'b001;
  localparam logic [2:0] OP_SET       = 3'b010;
  localparam logic [2:0] OP_CLR       = 3'b011;
  localparam logic [2:0] OP_TOGGLE    = 3'b100;
  localparam logic [2:0] OP_SWEEP_SET = 3'b101;
  localparam logic [2:0] OP_SWEEP_CLR = 3'b110;

  // Position field is one bit wider in the compare so that WIDTH itself fits.
  localparam logic [POS_W:0] WIDTH_LIM = (POS_W+1)'(WIDTH);

  // One-hot mask for bit p; a shift avoids indexing past the register when
  // WIDTH is not a power of two.
  function automatic logic [WIDTH-1:0] bit_mask(input logic [POS_W-1:0] p);
    return {{(WIDTH-1){1'b0}}, 1'b1} << p;
  endfunction

  function automatic logic [POS_W:0] popcount(input logic [WIDTH-1:0] d);
    logic [POS_W:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {{POS_W{1'b0}}, d[i]};
    end
    return n;
  endfunction

  state_e             state_q, state_d;
  logic [POS_W-1:0]   cur_pos_q, cur_pos_d;
  logic               sweep_set_q, sweep_set_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               pos_ok;
  logic [WIDTH-1:0]   cmd_mask;
  logic [WIDTH-1:0]   sweep_mask;

  assign pos_ok     = ({1'b0, position} < WIDTH_LIM);
  assign cmd_mask   = bit_mask(position);
  assign sweep_mask = bit_mask(cur_pos_q);

  always_comb begin
    state_d     = state_q;
    cur_pos_d   = cur_pos_q;
    sweep_set_d = sweep_set_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // cmd_ready is 1 throughout IDLE, so cmd_valid alone means acceptance.
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              data_d = data_in;
              done_d = 1'b1;
            end
            OP_SET, OP_CLR, OP_TOGGLE: begin
              if (pos_ok) begin
                if (cmd_op == OP_SET)      data_d = data_q | cmd_mask;
                else if (cmd_op == OP_CLR) data_d = data_q & ~cmd_mask;
                else                       data_d = data_q ^ cmd_mask;
                done_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SWEEP_SET, OP_SWEEP_CLR: begin
              if (pos_ok) begin
                // Bit p is handled on the acceptance edge; the remaining
                // bits p-1..0 are handled one per edge in SWEEP.
                if (cmd_op == OP_SWEEP_SET) data_d = data_q | cmd_mask;
                else                        data_d = data_q & ~cmd_mask;
                sweep_set_d = (cmd_op == OP_SWEEP_SET);
                if (position == '0) begin
                  done_d = 1'b1;
                end else begin
                  state_d   = SWEEP;
                  cur_pos_d = position - POS_W'(1);
                end
              end else begin
                err_d = 1'b1;
              end
            end
            default: ; // NOP and reserved code: no effect
          endcase
        end
      end
      SWEEP: begin
        if (sweep_set_q) data_d = data_q | sweep_mask;
        else             data_d = data_q & ~sweep_mask;
        if (cur_pos_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cur_pos_d = cur_pos_q - POS_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_pos_q   <= '0;
      sweep_set_q <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_pos_q   <= cur_pos_d;
      sweep_set_q <= sweep_set_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign data_out   = data_q;
  assign ones_count = popcount(data_q);
  assign busy       = (state_q == SWEEP);
  assign cmd_ready  = (state_q == IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule
